// File: rtl/rrat.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rrat: retirement register alias table with free-preg release and recovery   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module rrat #(
  parameter int PRF_SIZE = 64,
  parameter int PRF_LEN  = $clog2(PRF_SIZE)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    commit_valid,
  input  logic [4:0]              rob_commit_dest_areg_idx,
  input  logic [PRF_LEN-1:0]      rob_commit_dest_preg_idx,
  input  logic                    mis_pred_is_head,
  output logic                    rrat_free_valid,
  output logic [PRF_LEN-1:0]      rrat_free_preg_idx,
  output logic                    rrat_recover_valid,
  output logic [32*PRF_LEN-1:0]   rrat_map,
  output logic [PRF_SIZE-1:0]     rrat_free_vector
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } state_t;

  // Architectural regs 0..31 start mapped to pregs 0..31; the rest are free.
  localparam logic [PRF_SIZE-1:0] C_FREE_RESET = {{(PRF_SIZE-32){1'b1}}, 32'b0};

  state_t                r_state;
  state_t                w_state_next;
  logic [PRF_LEN-1:0]    r_map [32];
  logic [PRF_SIZE-1:0]   r_free_vec;
  logic                  r_free_valid;
  logic [PRF_LEN-1:0]    r_free_preg_idx;
  logic [PRF_LEN-1:0]    w_old;
  logic                  w_accept;

  assign w_old    = r_map[rob_commit_dest_areg_idx];
  // x0 never remaps, and a redundant commit must not free a still-live preg.
  assign w_accept = commit_valid && (r_state == IDLE) &&
                    (rob_commit_dest_areg_idx != 5'd0) &&
                    (rob_commit_dest_preg_idx != w_old);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (mis_pred_is_head) w_state_next = RECOVER;
      RECOVER: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_map[i] <= PRF_LEN'(i);
      end
      r_free_vec      <= C_FREE_RESET;
      r_free_valid    <= 1'b0;
      r_free_preg_idx <= '0;
    end else begin
      r_free_valid <= w_accept;
      if (w_accept) begin
        r_map[rob_commit_dest_areg_idx]      <= rob_commit_dest_preg_idx;
        r_free_vec[rob_commit_dest_preg_idx] <= 1'b0;
        r_free_vec[w_old]                    <= 1'b1;
        r_free_preg_idx                      <= w_old;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_map
      assign rrat_map[gi*PRF_LEN +: PRF_LEN] = r_map[gi];
    end
  endgenerate

  assign rrat_free_vector   = r_free_vec;
  assign rrat_free_valid    = r_free_valid;
  assign rrat_free_preg_idx = r_free_preg_idx;
  assign rrat_recover_valid = (r_state == RECOVER);

endmodule
`default_nettype wire
